// File: rtl/collision_checker.sv
// Collision probe for the player sprite: each 4-cycle sweep reads the two tiles just past
// the sprite edge in the pressed direction and reports whether either one is a wall.
module collision_checker #(
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPRITE   = 16
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [2:0]  mapa_x,
    input  logic [2:0]  mapa_y,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [16:0] tile_addr,
    output logic        tile_rd,
    input  logic        tile_data,
    output logic        collision,
    output logic        chk_valid
);

    typedef enum logic [1:0] {SNAP, RDA, RDB, UPD} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_DOWN, DIR_UP, DIR_RIGHT} dir_t;

    localparam logic [10:0] HS   = 11'(H_START);
    localparam logic [10:0] VS   = 11'(V_START);
    localparam logic [10:0] HA   = 11'(H_ACTIVE);
    localparam logic [10:0] VA   = 11'(V_ACTIVE);
    localparam logic [10:0] SPR  = 11'(SPRITE);
    localparam logic [10:0] ONE  = 11'd1;

    state_t      state, next_state;
    dir_t        live_dir, snap_dir;
    logic [9:0]  snap_x, snap_y;
    logic [2:0]  snap_mx, snap_my;
    logic        a_in, hit_a, hit_b;
    logic [17:0] probe_live, probe_b, drive;

    // Returns {in_area, tile address}; two's-complement 11-bit math, bit 10 is the sign.
    function automatic logic [17:0] probe(input logic [9:0] x, input logic [9:0] y,
                                          input logic [2:0] mx, input logic [2:0] my,
                                          input dir_t d, input logic second);
        logic [10:0] lx, ly, px, py;
        logic        in_area;
        lx = {1'b0, x} - HS;
        ly = {1'b0, y} - VS;
        px = lx;
        py = ly;
        in_area = 1'b1;
        case (d)
            DIR_LEFT:  begin px = lx - ONE;  py = second ? ly + SPR - ONE : ly; end
            DIR_RIGHT: begin px = lx + SPR;  py = second ? ly + SPR - ONE : ly; end
            DIR_UP:    begin py = ly - ONE;  px = second ? lx + SPR - ONE : lx; end
            DIR_DOWN:  begin py = ly + SPR;  px = second ? lx + SPR - ONE : lx; end
            default:   in_area = 1'b0;
        endcase
        if (px[10] || px >= HA || py[10] || py >= VA)
            in_area = 1'b0;
        probe = in_area ? {1'b1, my, mx, py[8:4], px[9:4]} : 18'd0;
    endfunction

    // Buttons are active-low; later assignments win, giving left > down > up > right.
    always_comb begin
        live_dir = DIR_NONE;
        if (!btn_right) live_dir = DIR_RIGHT;
        if (!btn_up)    live_dir = DIR_UP;
        if (!btn_down)  live_dir = DIR_DOWN;
        if (!btn_left)  live_dir = DIR_LEFT;
    end

    // Probe A is driven straight from the live inputs in SNAP so the ROM answers during RDA.
    always_comb begin
        probe_live = probe(x_pos, y_pos, mapa_x, mapa_y, live_dir, 1'b0);
        probe_b    = probe(snap_x, snap_y, snap_mx, snap_my, snap_dir, 1'b1);
        drive      = '0;
        next_state = state;
        case (state)
            SNAP: begin
                drive = probe_live;
                if (live_dir != DIR_NONE) next_state = RDA;
            end
            RDA: begin
                drive      = probe_b;
                next_state = RDB;
            end
            RDB:     next_state = UPD;
            UPD:     next_state = SNAP;
            default: next_state = SNAP;
        endcase
        if (reset) drive = '0;
        tile_rd   = drive[17];
        tile_addr = drive[16:0];
    end

    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state     <= SNAP;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_mx   <= '0;
            snap_my   <= '0;
            snap_dir  <= DIR_NONE;
            a_in      <= 1'b0;
            hit_a     <= 1'b0;
            hit_b     <= 1'b0;
            collision <= 1'b0;
            chk_valid <= 1'b0;
        end else begin
            state     <= next_state;
            chk_valid <= 1'b0;
            case (state)
                SNAP: begin
                    snap_x   <= x_pos;
                    snap_y   <= y_pos;
                    snap_mx  <= mapa_x;
                    snap_my  <= mapa_y;
                    snap_dir <= live_dir;
                    a_in     <= probe_live[17];
                    if (live_dir == DIR_NONE) begin
                        collision <= 1'b0;
                        chk_valid <= 1'b1;
                    end
                end
                RDA: hit_a <= tile_data & a_in;
                RDB: hit_b <= tile_data & probe_b[17];
                UPD: begin
                    collision <= hit_a | hit_b;
                    chk_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker: tile ROM model, sweep-level reference model checked every
// cycle, and directed scenarios with hand-computed addresses and collision results.
module tb_collision_checker;

    logic        CLOCK_25 = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_pos = 10'd300;
    logic [9:0]  y_pos = 10'd200;
    logic [2:0]  mapa_x = 3'd1;
    logic [2:0]  mapa_y = 3'd1;
    logic        btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
    logic [16:0] tile_addr;
    logic        tile_rd;
    logic        tile_data = 1'b0;
    logic        collision;
    logic        chk_valid;

    int total = 0;
    int bad = 0;
    bit romMem [0:131071];

    collision_checker dut (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .mapa_x   (mapa_x),
        .mapa_y   (mapa_y),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .tile_addr(tile_addr),
        .tile_rd  (tile_rd),
        .tile_data(tile_data),
        .collision(collision),
        .chk_valid(chk_valid)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    // The ROM always reads, so masking of out-of-area probes is exercised too.
    always @(posedge CLOCK_25) tile_data <= romMem[tile_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int dirOf();
        if (!btn_left)  return 1;
        if (!btn_down)  return 2;
        if (!btn_up)    return 3;
        if (!btn_right) return 4;
        return 0;
    endfunction

    function automatic void probeOf(input int x, input int y, input int mx, input int my,
                                    input int dir, input int slot,
                                    output bit inArea, output int addr);
        int lx, ly, px, py;
        lx = x - 144;
        ly = y - 35;
        case (dir)
            1:       begin px = lx - 1;  py = ly + slot * 15; end
            4:       begin px = lx + 16; py = ly + slot * 15; end
            3:       begin py = ly - 1;  px = lx + slot * 15; end
            default: begin py = ly + 16; px = lx + slot * 15; end
        endcase
        inArea = (px >= 0) && (px < 640) && (py >= 0) && (py < 480);
        addr = inArea ? (my * 16384 + mx * 2048 + (py / 16) * 64 + px / 16) : 0;
    endfunction

    // Reference model: tracks the position within a sweep and checks every cycle.
    int  phase = 0;
    bit  expColl = 0, expValid = 0, nextValid;
    bit  mInA, mInB, hitA, hitB;
    int  mAddrA, mAddrB, mDir;

    always @(negedge CLOCK_25) begin
        if (reset) begin
            phase = 0;
            expColl = 0;
            expValid = 0;
            checkOutput("rst_collision", collision, 0);
            checkOutput("rst_chk_valid", chk_valid, 0);
            checkOutput("rst_tile_rd", tile_rd, 0);
            checkOutput("rst_tile_addr", tile_addr, 0);
        end else begin
            checkOutput("model_collision", collision, expColl);
            checkOutput("model_chk_valid", chk_valid, expValid);
            nextValid = 0;
            case (phase)
                0: begin
                    mDir = dirOf();
                    if (mDir == 0) begin
                        checkOutput("model_idle_rd", tile_rd, 0);
                        checkOutput("model_idle_addr", tile_addr, 0);
                        expColl = 0;
                        nextValid = 1;
                    end else begin
                        probeOf(x_pos, y_pos, mapa_x, mapa_y, mDir, 0, mInA, mAddrA);
                        probeOf(x_pos, y_pos, mapa_x, mapa_y, mDir, 1, mInB, mAddrB);
                        checkOutput("model_rd_a", tile_rd, mInA);
                        checkOutput("model_addr_a", tile_addr, mAddrA);
                        hitA = mInA && romMem[mAddrA];
                        phase = 1;
                    end
                end
                1: begin
                    checkOutput("model_rd_b", tile_rd, mInB);
                    checkOutput("model_addr_b", tile_addr, mAddrB);
                    hitB = mInB && romMem[mAddrB];
                    phase = 2;
                end
                2: begin
                    checkOutput("model_rd_quiet", tile_rd, 0);
                    phase = 3;
                end
                default: begin
                    checkOutput("model_rd_quiet", tile_rd, 0);
                    expColl = hitA || hitB;
                    nextValid = 1;
                    phase = 0;
                end
            endcase
            expValid = nextValid;
        end
    end

    task automatic waitPos();
        @(posedge CLOCK_25);
        #5;
    endtask

    task automatic sampleCycle();
        @(negedge CLOCK_25);
        #1;
    endtask

    task automatic romFill(input bit v);
        for (int i = 0; i < 131072; i++) romMem[i] = v;
    endtask

    task automatic applyStimulus(input int x, input int y, input int mx, input int my,
                                 input bit l, input bit d, input bit u, input bit r);
        x_pos = 10'(x);
        y_pos = 10'(y);
        mapa_x = 3'(mx);
        mapa_y = 3'(my);
        btn_left = ~l;
        btn_down = ~d;
        btn_up = ~u;
        btn_right = ~r;
    endtask

    task automatic holdReset();
        waitPos();
        reset = 1'b1;
    endtask

    // The cycle following the release is the first SNAP cycle.
    task automatic releaseReset();
        waitPos();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        romFill(0);
        sampleCycle();
        checkOutput("reset_collision", collision, 0);
        checkOutput("reset_tile_addr", tile_addr, 0);

        // Right probes at x=300,y=200, room (1,1); x change mid-sweep is ignored.
        holdReset();
        applyStimulus(300, 200, 1, 1, 0, 0, 0, 1);
        releaseReset();
        sampleCycle();
        checkOutput("right_addr_a", tile_addr, 19082);
        checkOutput("right_rd_a", tile_rd, 1);
        waitPos();
        applyStimulus(500, 200, 1, 1, 0, 0, 0, 1);
        sampleCycle();
        checkOutput("right_addr_b", tile_addr, 19146);
        sampleCycle();
        sampleCycle();
        checkOutput("right_valid_c3", chk_valid, 0);
        sampleCycle();
        checkOutput("right_valid_c4", chk_valid, 1);
        checkOutput("right_coll_free", collision, 0);
        checkOutput("right_addr_newx", tile_addr, 19095);

        // Wall at probe B: collision 3 cycles after SNAP, cleared one sweep later.
        holdReset();
        romFill(0);
        romMem[19146] = 1;
        applyStimulus(300, 200, 1, 1, 0, 0, 0, 1);
        releaseReset();
        repeat (4) sampleCycle();
        checkOutput("wall_coll_c3", collision, 0);
        sampleCycle();
        checkOutput("wall_coll_c4", collision, 1);
        waitPos();
        romMem[19146] = 0;
        repeat (3) sampleCycle();
        checkOutput("wall_coll_hold", collision, 1);
        sampleCycle();
        checkOutput("wall_coll_clear", collision, 0);

        // Reset during RDA aborts the sweep; the next sweep restarts from SNAP.
        holdReset();
        romMem[19146] = 1;
        releaseReset();
        repeat (5) sampleCycle();
        checkOutput("abort_coll_set", collision, 1);
        waitPos();
        reset = 1'b1;
        #1;
        checkOutput("abort_coll_zero", collision, 0);
        checkOutput("abort_rd_zero", tile_rd, 0);
        waitPos();
        reset = 1'b0;
        sampleCycle();
        checkOutput("abort_restart_addr", tile_addr, 19082);
        repeat (4) sampleCycle();
        checkOutput("abort_restart_coll", collision, 1);

        // Left edge of the screen: both probes off-area, ROM all walls.
        holdReset();
        romFill(1);
        applyStimulus(144, 200, 1, 1, 1, 0, 0, 0);
        releaseReset();
        for (int i = 0; i < 8; i++) begin
            sampleCycle();
            checkOutput("offmap_rd", tile_rd, 0);
        end
        checkOutput("offmap_coll", collision, 0);

        // Bottom edge: y=499 puts probes at py=480 (off), y=498 at py=479 (on).
        holdReset();
        applyStimulus(300, 499, 1, 1, 0, 1, 0, 0);
        releaseReset();
        repeat (5) sampleCycle();
        checkOutput("bottom_off_coll", collision, 0);
        holdReset();
        applyStimulus(300, 498, 1, 1, 0, 1, 0, 0);
        releaseReset();
        repeat (5) sampleCycle();
        checkOutput("bottom_on_coll", collision, 1);

        // Left and right held with walls only on the right: left wins.
        holdReset();
        romFill(0);
        romMem[19082] = 1;
        romMem[19146] = 1;
        applyStimulus(300, 200, 1, 1, 1, 0, 0, 1);
        releaseReset();
        sampleCycle();
        checkOutput("prio_addr_left", tile_addr, 19081);
        repeat (4) sampleCycle();
        checkOutput("prio_coll", collision, 0);

        // No button: collision cleared and chk_valid every cycle.
        waitPos();
        applyStimulus(300, 200, 1, 1, 0, 0, 0, 0);
        repeat (6) sampleCycle();
        checkOutput("idle_valid", chk_valid, 1);
        checkOutput("idle_coll", collision, 0);
        checkOutput("idle_rd", tile_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
